// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
// Two-master Wishbone arbiter sharing one slave bus between the management
// core (master 0) and the DMA engine (master 1).
//   - Registered round-robin grant; one IDLE bubble precedes every new grant.
//   - Burst limit: an owner that takes MAX_BURST acks while the other master
//     waits is preempted at the transfer boundary and must wait to be re-granted.
//   - Watchdog: TIMEOUT cycles of unacknowledged strobe raise a one-cycle
//     error to the owner and a timeout_o pulse, with the strobe masked that cycle.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   m0_* / m1_*                  master-side Wishbone (cyc/stb/we/sel/adr/dat in,
//                                ack/err out); m_dat_o is shared read data
//   s_*                          slave-side Wishbone
//   gnt_o                        one-hot owner, 00 when idle
//   timeout_o                    one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [DW-1:0] m_dat_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o,
    output logic          timeout_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);
    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [9:0] wdog_cnt_q, wdog_cnt_d;
    logic       hold_q, hold_d;

    logic own0, own1, owned;
    logic own_cyc, own_stb, oth_cyc;
    logic fwd_ack;
    logic [8:0] burst_inc;

    assign own0  = (state_q == S_OWN0);
    assign own1  = (state_q == S_OWN1);
    assign owned = own0 | own1;

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        oth_cyc = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (own0) begin
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
            oth_cyc = m1_cyc_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (own1) begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
            oth_cyc = m0_cyc_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // Slave controls depend only on registered state and master inputs,
    // never on s_ack_i.
    assign s_cyc_o = own_cyc;
    assign s_stb_o = own_stb & ~hold_q;
    assign fwd_ack = s_ack_i & s_stb_o;

    assign m0_ack_o  = fwd_ack & own0;
    assign m1_ack_o  = fwd_ack & own1;
    assign m0_err_o  = hold_q & own0;
    assign m1_err_o  = hold_q & own1;
    assign m_dat_o   = owned ? s_dat_i : '0;
    assign gnt_o     = {own1, own0};
    assign timeout_o = hold_q;

    assign burst_inc = {1'b0, burst_cnt_q} + 9'd1;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        wdog_cnt_d  = '0;
        hold_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                burst_cnt_d = '0;
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? S_OWN0 : S_OWN1;
                else if (m0_cyc_i)        state_d = S_OWN0;
                else if (m1_cyc_i)        state_d = S_OWN1;
            end
            S_OWN0, S_OWN1: begin
                if (!own_cyc) begin
                    state_d     = S_IDLE;
                    last_d      = own1;
                    burst_cnt_d = '0;
                end else if (fwd_ack && oth_cyc) begin
                    // Preempt only right after a completed transfer.
                    if (burst_inc >= BURST_LIM) begin
                        state_d     = S_IDLE;
                        last_d      = own1;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_inc[7:0];
                    end
                end else if (!oth_cyc) begin
                    burst_cnt_d = '0;
                end

                // An ack in the expiry cycle takes priority over the error.
                if (s_stb_o && !s_ack_i) begin
                    if (wdog_cnt_q == WDOG_LAST) hold_d = own_cyc;
                    else                         wdog_cnt_d = wdog_cnt_q + 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            wdog_cnt_d = '0;
            hold_d     = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            wdog_cnt_q  <= '0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            wdog_cnt_q  <= wdog_cnt_d;
            hold_q      <= hold_d;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_bus_arbiter
// Directed bench for wb_bus_arbiter (TIMEOUT=8, MAX_BURST=16). Inputs change
// 1ns after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_bus_arbiter;

    localparam logic [31:0] BASE = 32'h3800_0130;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_dat;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_dat;
    logic [31:0] m_dat;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [1:0]  gnt;
    logic        tmo;

    logic slv_auto, slv_force;
    assign s_ack   = (slv_auto & s_stb) | slv_force;
    assign s_dat_i = 32'h0000_1234;

    wb_bus_arbiter #(.AW(32), .DW(32), .MAX_BURST(16), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m_dat_o(m_dat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
        .gnt_o(gnt), .timeout_o(tmo)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic idle_masters();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hf; m0_adr = 32'h3000_0000; m0_dat = 32'hc0de_0000;
        m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_sel = 4'hf; m1_adr = BASE;          m1_dat = 32'hd0a0_0000;
        slv_auto = 0; slv_force = 0;
    endtask

    // Leaves the bench 1ns after a rising edge with reset released (cycle 0).
    task automatic do_reset();
        idle_masters();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int dma_n, cpu_n, dma_at_cpu, bad_adr, bad_gnt, burst_max, gnt_drop;
    int err_n, to_n, ack_n, err_cyc, ack_cyc;
    logic stb_at_err, got0, got1, gerr;

    initial begin
        idle_masters();
        // ---------------- reset state ----------------
        rst_n = 0;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_scyc_stb", {30'd0, s_cyc, s_stb}, 0);
        chk("rst_sadr", s_adr, 0);
        chk("rst_mdat", m_dat, 0);
        chk("rst_ack_err_tmo", {27'd0, m0_ack, m0_err, m1_ack, m1_err, tmo}, 0);

        // ---------------- single CPU read ----------------
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        @(negedge clk); chk("rd_c0_gnt", 32'(gnt), 0);
        step();
        @(negedge clk);
        chk("rd_c1_gnt", 32'(gnt), 32'b01);
        chk("rd_c1_stb", 32'(s_stb), 1);
        chk("rd_c1_adr", s_adr, 32'h3000_0000);
        chk("rd_c1_ack", 32'(m0_ack), 0);
        step(); slv_force = 1;
        @(negedge clk);
        chk("rd_c2_ack", 32'(m0_ack), 1);
        chk("rd_c2_mdat", m_dat, 32'h1234);
        chk("rd_c2_m1ack", 32'(m1_ack), 0);
        step(); slv_force = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk); chk("rd_c3_scyc", 32'(s_cyc), 0);
        step();
        @(negedge clk); chk("rd_c4_gnt", 32'(gnt), 0);

        // ---------------- tie after reset ----------------
        do_reset();
        slv_auto = 1;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge clk); chk("tie_c0_gnt", 32'(gnt), 0);
        step();
        @(negedge clk);
        chk("tie_c1_gnt", 32'(gnt), 32'b01);
        chk("tie_c1_acks", {30'd0, m0_ack, m1_ack}, 32'b10);
        step(); m0_cyc = 0; m0_stb = 0;
        @(negedge clk); chk("tie_c2_m1ack", 32'(m1_ack), 0);
        step();
        @(negedge clk); chk("tie_c3_bubble", 32'(gnt), 0);
        step();
        @(negedge clk);
        chk("tie_c4_gnt", 32'(gnt), 32'b10);
        chk("tie_c4_m1ack", 32'(m1_ack), 1);
        step(); m1_cyc = 0; m1_stb = 0;

        // ---------------- burst limit ----------------
        do_reset();
        slv_auto = 1;
        m1_cyc = 1; m1_stb = 1; m1_adr = BASE;
        dma_n = 0; cpu_n = 0; dma_at_cpu = -1; bad_adr = 0; bad_gnt = 0;
        for (int c = 0; c < 300 && dma_n < 64; c++) begin
            @(negedge clk);
            got0 = m0_ack; got1 = m1_ack;
            if (got1) begin
                if (s_adr !== BASE + 32'(4 * dma_n)) bad_adr++;
                if (gnt !== 2'b10) bad_gnt++;
                dma_n++;
            end
            if (got0) begin
                cpu_n++;
                dma_at_cpu = dma_n;
                if (gnt !== 2'b01) bad_gnt++;
            end
            step();
            if (got1) m1_adr = BASE + 32'(4 * dma_n);
            if (got1 && dma_n == 2) begin m0_cyc = 1; m0_stb = 1; end
            if (got0) begin m0_cyc = 0; m0_stb = 0; end
            if (dma_n == 64) begin m1_cyc = 0; m1_stb = 0; end
        end
        chk("bl_dma_acks", 32'(dma_n), 64);
        chk("bl_cpu_acks", 32'(cpu_n), 1);
        chk("bl_preempt_at", 32'(dma_at_cpu), 18);
        chk("bl_addr_errs", 32'(bad_adr), 0);
        chk("bl_gnt_errs", 32'(bad_gnt), 0);
        idle_masters();
        step(); step();

        // ---------------- burst counter clear (CPU idle) ----------------
        do_reset();
        slv_auto = 1;
        m1_cyc = 1; m1_stb = 1;
        dma_n = 0; burst_max = 0; gnt_drop = 0;
        for (int c = 0; c < 100 && dma_n < 40; c++) begin
            @(negedge clk);
            if (c >= 1 && gnt !== 2'b10) gnt_drop++;
            if (int'(dut.burst_cnt_q) > burst_max) burst_max = int'(dut.burst_cnt_q);
            if (m1_ack) dma_n++;
            step();
            if (dma_n == 40) begin m1_cyc = 0; m1_stb = 0; end
        end
        chk("bc_acks", 32'(dma_n), 40);
        chk("bc_gnt_drop", 32'(gnt_drop), 0);
        chk("bc_burst_max", 32'(burst_max), 0);
        step(); step();

        // ---------------- watchdog timeout ----------------
        do_reset();
        m1_cyc = 1; m1_stb = 1;
        err_n = 0; to_n = 0; ack_n = 0; err_cyc = -1; stb_at_err = 1'bx;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            gerr = m1_err;
            if (gerr) begin
                err_n++;
                if (err_cyc < 0) begin err_cyc = c; stb_at_err = s_stb; end
            end
            if (tmo) to_n++;
            if (m1_ack) ack_n++;
            step();
            // Late ack lands in the expected hold cycle and must be dropped.
            slv_force = (c + 1 == 9);
            if (gerr) begin m1_cyc = 0; m1_stb = 0; end
        end
        chk("to_err_count", 32'(err_n), 1);
        chk("to_pulse_count", 32'(to_n), 1);
        chk("to_err_cycle", 32'(err_cyc), 9);
        chk("to_stb_at_err", 32'(stb_at_err), 0);
        chk("to_no_ack", 32'(ack_n), 0);
        idle_masters();

        // ---------------- ack in the expiry cycle wins ----------------
        do_reset();
        m1_cyc = 1; m1_stb = 1;
        err_n = 0; to_n = 0; ack_n = 0; ack_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            got1 = m1_ack;
            if (m1_err) err_n++;
            if (tmo) to_n++;
            if (got1) begin ack_n++; ack_cyc = c; end
            step();
            slv_force = (c + 1 == 8);
            if (got1) begin m1_cyc = 0; m1_stb = 0; end
        end
        chk("aw_ack_cycle", 32'(ack_cyc), 8);
        chk("aw_ack_count", 32'(ack_n), 1);
        chk("aw_no_err", 32'(err_n + to_n), 0);
        idle_masters();

        // ---------------- async reset mid-burst ----------------
        do_reset();
        slv_auto = 1;
        m1_cyc = 1; m1_stb = 1;
        repeat (5) step();
        @(negedge clk);
        chk("ar_pre_gnt", 32'(gnt), 32'b10);
        #2 rst_n = 0;
        #1;
        chk("ar_gnt", 32'(gnt), 0);
        chk("ar_scyc_stb", {30'd0, s_cyc, s_stb}, 0);
        chk("ar_sadr_sdat", s_adr | s_dat_o, 0);
        chk("ar_m1ack_mdat", {31'd0, m1_ack} | m_dat, 0);
        m0_cyc = 1; m0_stb = 1;
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk); chk("ar_c0_gnt", 32'(gnt), 0);
        step();
        @(negedge clk); chk("ar_tie_gnt", 32'(gnt), 32'b01);
        idle_masters();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master Wishbone arbiter. It shares the single user-project slave bus between the management-core Wishbone port (master 0) and the DMA engine master port (master 1).
- Arbitration is round-robin with a per-owner burst limit, so a long DMA stream (FIR tap load, matrix fill) cannot starve CPU accesses.
- A watchdog terminates transfers that the slave never acknowledges, returning an error to the stalled master.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 16, acks an owner may take back-to-back while the other master is waiting; range 1..255.
- TIMEOUT, 255, cycles of unacknowledged strobe before forced error termination; range 2..1023.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_ni  in  1  asynchronous reset, active low
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (CPU) controls
- m0_sel_i  in  4  master 0 byte selects
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_ack_o, m0_err_o  out  1 each  master 0 handshake
- m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i  in  as m0  master 1 (DMA)
- m1_ack_o, m1_err_o  out  1 each  master 1 handshake
- m_dat_o  out  DW  read data, broadcast to both masters
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls
- s_sel_o  out  4  slave byte selects
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current owner; 00 when idle
- timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - State goes to IDLE; last_q=1, so master 0 wins the first tie.
  - burst_cnt=0, wdog_cnt=0.
  - All s_* outputs, ack/err outputs, gnt_o, timeout_o and m_dat_o are 0.
- States: IDLE, OWN0, OWN1. The grant is registered, so there is 1 cycle of arbitration latency from cyc to the slave seeing strobe.
- IDLE:
  - Only mX_cyc_i high: go to OWNX.
  - Both high: grant the master != last_q.
  - Neither high: stay in IDLE.
- OWNX, forwarding:
  - s_cyc_o = mX_cyc_i.
  - s_stb_o = mX_stb_i & ~hold.
  - s_we_o/s_sel_o/s_adr_o/s_dat_o come combinationally from master X.
  - mX_ack_o = s_ack_i & s_stb_o.
  - The non-owner's ack and err are always 0.
  - m_dat_o = s_dat_i.
- OWNX, leaving: mX_cyc_i low goes to IDLE and sets last_q=X. One idle bubble always precedes a new grant.
- Burst limit:
  - burst_cnt increments on each forwarded ack while the other master's cyc is high. It is cleared when the other master's cyc is low or on a grant change.
  - burst_cnt reaching MAX_BURST on an ack cycle forces the next state to IDLE with last_q=X. This is preemption at a transfer boundary only.
  - The owner keeps cyc/stb asserted and simply stalls without ack until re-granted.
  - The other master then wins from IDLE.
- Watchdog:
  - wdog_cnt counts cycles with s_stb_o high and s_ack_i low. It is cleared on ack or when the strobe drops.
  - When wdog_cnt = TIMEOUT-1 with no ack, the next cycle behaves as follows:
    - mX_err_o=1 and timeout_o=1 for one cycle.
    - hold=1, so s_stb_o=0 for that cycle.
    - wdog_cnt clears.
  - The owner stays granted. A late s_ack_i arriving during hold is ignored and produces no mX_ack_o.
- Simultaneous events:
  - An ack in the same cycle as expiry: the ack wins and no error is raised.
  - The owner dropping cyc in the same cycle as the burst limit: go to IDLE, same as a normal exit.
- Reset mid-transfer: all outputs drop asynchronously. Masters must restart their transfers.
- No combinational path from s_ack_i to any s_* output.

Test Plan:
- Single CPU read, m1 idle: m0_cyc/stb at cycle 0, slave ack in cycle 2 with s_dat_i=0x1234 → gnt_o=01 from cycle 1; m0_ack_o=1 and m_dat_o=0x1234 in cycle 2; gnt_o=00 after cyc drops.
- Tie at reset: both cyc rise together → master 0 granted first. After m0 completes, master 1 is granted following a 1-cycle IDLE bubble.
- Burst limit: DMA streams 64 single-cycle acks to 0x38000130 onward; CPU raises cyc at DMA ack #3 → after 16 forwarded acks the DMA is held. The CPU transfer completes, then the DMA resumes at the correct next address with no lost or duplicate ack.
- Burst counter clear: DMA streams 40 acks with CPU idle → no preemption and burst_cnt stays 0.
- Timeout: TIMEOUT=8, slave never acks m1 → m1_err_o and timeout_o pulse exactly once, 8 cycles after strobe is forwarded; s_stb_o is 0 that cycle and m1_ack_o is never asserted.
- Async reset mid-burst: wb_rst_ni low while OWN1 → all s_* and gnt_o are 0 immediately without a clock edge. After release, the first tie grants master 0.
